debug_unlock_controller: RTL and testbench

Challenge-response gate that sits directly upstream of the debug-sensitive block and drives its `debug_level` input. The debug level stays 0 until an external debugger answers a nonce challenge with the correct key-derived response. The controller enforces a per-session timeout, a response timeout and an attempt lockout. The granted level is capped at a parameterised maximum.

---
 rtl/debug_unlock_controller.sv | 164 ++++++++++++++++
 tb/tb_debug_unlock_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unlock_controller.sv
// Challenge-response gate for the downstream debug level: a nonce is issued per
// request, and the level is granted only for a correct key-derived response.
module debug_unlock_controller #(
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1024,
  parameter int unsigned SESSION_CYCLES = 65535,
  parameter int unsigned RESP_TIMEOUT   = 256,
  parameter logic [3:0]  MAX_LEVEL      = 4'hB,
  parameter logic [31:0] LFSR_SEED      = 32'hACE1_1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] unlock_key,
  input  logic        req_valid,
  input  logic [3:0]  req_level,
  output logic        req_ready,
  output logic [31:0] challenge,
  output logic        challenge_valid,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        relock,
  output logic [3:0]  debug_level,
  output logic        unlocked,
  output logic        locked_out,
  output logic [2:0]  fail_count
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHAL,
    S_CHECK,
    S_UNLOCK,
    S_LOCKOUT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] lfsr;
  logic [31:0] cnt, cnt_nxt;
  logic [3:0]  level_q, level_nxt;
  logic        match_q, match_nxt;
  logic [2:0]  fail_nxt;
  logic [31:0] challenge_nxt;
  logic        fail_hit;
  logic        grant;

  function automatic logic [3:0] cap_level(input logic [3:0] lvl);
    return (lvl > MAX_LEVEL) ? MAX_LEVEL : lvl;
  endfunction

  function automatic logic [2:0] sat_fail_inc(input logic [2:0] c);
    if ({29'd0, c} + 32'd1 >= MAX_ATTEMPTS)
      return 3'(MAX_ATTEMPTS);
    else
      return c + 3'd1;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // One shared down-counter serves as response, session and lockout timer.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    level_nxt     = level_q;
    match_nxt     = match_q;
    fail_nxt      = fail_count;
    challenge_nxt = challenge;
    fail_hit      = 1'b0;
    req_ready     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          level_nxt     = cap_level(req_level);
          challenge_nxt = lfsr;
          cnt_nxt       = RESP_TIMEOUT - 1;
          state_nxt     = S_CHAL;
        end
      end
      S_CHAL: begin
        if (resp_valid) begin
          match_nxt = (resp_data == (unlock_key ^ challenge));
          state_nxt = S_CHECK;
        end else if (cnt == '0) begin
          fail_hit = 1'b1;
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      S_CHECK: begin
        if (match_q) begin
          fail_nxt      = '0;
          cnt_nxt       = SESSION_CYCLES - 1;
          challenge_nxt = '0;
          state_nxt     = S_UNLOCK;
        end else begin
          fail_hit = 1'b1;
        end
      end
      S_UNLOCK: begin
        if (cnt == '0 || relock)
          state_nxt = S_IDLE;
        else
          cnt_nxt = cnt - 32'd1;
      end
      S_LOCKOUT: begin
        if (cnt == '0) begin
          fail_nxt  = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // A wrong answer and a response timeout share the same failure path.
    if (fail_hit) begin
      fail_nxt = sat_fail_inc(fail_count);
      if ({29'd0, fail_nxt} == MAX_ATTEMPTS) begin
        cnt_nxt       = LOCKOUT_CYCLES - 1;
        challenge_nxt = '0;
        state_nxt     = S_LOCKOUT;
      end else begin
        state_nxt = S_IDLE;
      end
    end
  end

  // relock drops the grant on the very edge that samples it.
  assign grant = (state == S_UNLOCK) && !relock;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      lfsr            <= LFSR_SEED;
      cnt             <= '0;
      level_q         <= '0;
      match_q         <= 1'b0;
      fail_count      <= '0;
      challenge       <= '0;
      challenge_valid <= 1'b0;
      debug_level     <= '0;
      unlocked        <= 1'b0;
      locked_out      <= 1'b0;
    end else begin
      state           <= state_nxt;
      lfsr            <= lfsr_step(lfsr);
      cnt             <= cnt_nxt;
      level_q         <= level_nxt;
      match_q         <= match_nxt;
      fail_count      <= fail_nxt;
      challenge       <= challenge_nxt;
      challenge_valid <= (state_nxt == S_CHAL);
      debug_level     <= grant ? level_q : 4'd0;
      unlocked        <= grant;
      locked_out      <= (state == S_LOCKOUT);
    end
  end

endmodule

// File: tb/tb_debug_unlock_controller.sv
// Directed bench for debug_unlock_controller with small timer parameters.
module tb_debug_unlock_controller;

  localparam int unsigned MAX_ATTEMPTS   = 3;
  localparam int unsigned LOCKOUT_CYCLES = 8;
  localparam int unsigned SESSION_CYCLES = 16;
  localparam int unsigned RESP_TIMEOUT   = 6;
  localparam logic [31:0] SEED           = 32'hACE1_1234;
  localparam logic [31:0] KEY            = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] unlock_key;
  logic        req_valid;
  logic [3:0]  req_level;
  logic        req_ready;
  logic [31:0] challenge;
  logic        challenge_valid;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        relock;
  logic [3:0]  debug_level;
  logic        unlocked;
  logic        locked_out;
  logic [2:0]  fail_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_lfsr;
  logic [31:0] chal;
  int          cnt_hi;
  int          first_hi;

  debug_unlock_controller #(
    .MAX_ATTEMPTS  (MAX_ATTEMPTS),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .SESSION_CYCLES(SESSION_CYCLES),
    .RESP_TIMEOUT  (RESP_TIMEOUT),
    .MAX_LEVEL     (4'hB),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .unlock_key     (unlock_key),
    .req_valid      (req_valid),
    .req_level      (req_level),
    .req_ready      (req_ready),
    .challenge      (challenge),
    .challenge_valid(challenge_valid),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .relock         (relock),
    .debug_level    (debug_level),
    .unlocked       (unlocked),
    .locked_out     (locked_out),
    .fail_count     (fail_count)
  );

  always #5 clk = ~clk;

  // Reference nonce generator, Galois form with taps 32'h8020_0003.
  always @(posedge clk or negedge rst) begin
    if (!rst)
      m_lfsr <= SEED;
    else
      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string where);
    check({where, "_debug_level"}, 32'(debug_level), 32'd0);
    check({where, "_unlocked"}, 32'(unlocked), 32'd0);
    check({where, "_locked_out"}, 32'(locked_out), 32'd0);
    check({where, "_fail_count"}, 32'(fail_count), 32'd0);
    check({where, "_challenge"}, challenge, 32'd0);
    check({where, "_challenge_valid"}, 32'(challenge_valid), 32'd0);
    check({where, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Returns the nonce the DUT latches on the handshake edge.
  task automatic request(input logic [3:0] lvl, output logic [31:0] c);
    req_valid = 1'b1;
    req_level = lvl;
    c = m_lfsr;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic fail_attempt(input int idx);
    logic [31:0] c;
    request(4'h1, c);
    resp_valid = 1'b1;
    resp_data  = 32'h0;
    tick();
    resp_valid = 1'b0;
    tick();
    check("fail_count_step", 32'(fail_count), 32'(idx));
  endtask

  initial begin
    rst        = 1'b0;
    unlock_key = KEY;
    req_valid  = 1'b0;
    req_level  = 4'h0;
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    relock     = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Correct unlock at level 9, then relock.
    request(4'h9, chal);
    check("chal_value", challenge, chal);
    check("chal_valid", 32'(challenge_valid), 32'd1);
    check("busy_not_ready", 32'(req_ready), 32'd0);
    resp_valid = 1'b1;
    resp_data  = chal ^ KEY;
    tick();
    resp_valid = 1'b0;
    check("unl_in_check", 32'(unlocked), 32'd0);
    tick();
    check("unl_r_plus1", 32'(unlocked), 32'd0);
    tick();
    check("unl_r_plus2", 32'(unlocked), 32'd1);
    check("lvl9", 32'(debug_level), 32'h9);
    check("unl_fail0", 32'(fail_count), 32'd0);
    check("unl_chal_clr", challenge, 32'd0);
    check("unl_not_ready", 32'(req_ready), 32'd0);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    check("relock_lvl", 32'(debug_level), 32'd0);
    check("relock_unl", 32'(unlocked), 32'd0);
    check("relock_ready", 32'(req_ready), 32'd1);

    // Level cap and full session length.
    request(4'hF, chal);
    resp_valid = 1'b1;
    resp_data  = chal ^ KEY;
    cnt_hi   = 0;
    first_hi = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      resp_valid = 1'b0;
      if (debug_level == 4'hB) begin
        cnt_hi++;
        if (first_hi < 0) first_hi = k;
      end
    end
    check("cap_first", 32'(first_hi), 32'd3);
    check("cap_cycles", 32'(cnt_hi), 32'(SESSION_CYCLES));
    check("expire_lvl", 32'(debug_level), 32'd0);
    check("expire_ready", 32'(req_ready), 32'd1);

    // Three wrong answers cause lockout.
    for (int i = 1; i <= 3; i++) fail_attempt(i);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("lo_not_ready", 32'(req_ready), 32'd0);
    check("lo_no_chal", 32'(challenge_valid), 32'd0);
    check("lo_flag", 32'(locked_out), 32'd1);
    check("lo_fail3", 32'(fail_count), 32'd3);
    cnt_hi = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (locked_out) cnt_hi++;
    end
    check("lo_cycles", 32'(cnt_hi), 32'(LOCKOUT_CYCLES));
    check("lo_fail_clr", 32'(fail_count), 32'd0);
    check("lo_ready_after", 32'(req_ready), 32'd1);

    // Response timeout counts as one failure.
    request(4'h2, chal);
    cnt_hi = 0;
    for (int k = 0; k < 10; k++) begin
      if (challenge_valid) cnt_hi++;
      tick();
    end
    check("to_window", 32'(cnt_hi), 32'(RESP_TIMEOUT));
    check("to_fail1", 32'(fail_count), 32'd1);
    check("to_idle", 32'(req_ready), 32'd1);

    // Response on the final window cycle wins over the timeout.
    request(4'h3, chal);
    for (int k = 0; k < RESP_TIMEOUT - 1; k++) tick();
    check("tie_still_chal", 32'(challenge_valid), 32'd1);
    resp_valid = 1'b1;
    resp_data  = chal ^ KEY;
    tick();
    resp_valid = 1'b0;
    tick();
    tick();
    check("tie_unl", 32'(unlocked), 32'd1);
    check("tie_lvl", 32'(debug_level), 32'h3);
    check("tie_fail0", 32'(fail_count), 32'd0);

    // relock coincident with session expiry.
    for (int k = 4; k <= 17; k++) tick();
    check("pre_exp_lvl", 32'(debug_level), 32'h3);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    check("relexp_lvl", 32'(debug_level), 32'd0);
    check("relexp_unl", 32'(unlocked), 32'd0);
    check("relexp_ready", 32'(req_ready), 32'd1);
    tick();
    check("relexp_stay_ready", 32'(req_ready), 32'd1);
    check("relexp_no_chal", 32'(challenge_valid), 32'd0);

    // Asynchronous reset during UNLOCK.
    request(4'h5, chal);
    resp_valid = 1'b1;
    resp_data  = chal ^ KEY;
    tick();
    resp_valid = 1'b0;
    tick();
    tick();
    check("rst_unl_pre", 32'(unlocked), 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_unlock");
    tick();
    rst = 1'b1;
    tick();

    // Asynchronous reset during LOCKOUT.
    for (int i = 1; i <= 3; i++) fail_attempt(i);
    tick();
    check("rst_lo_pre", 32'(locked_out), 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_lockout");
    tick();
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
